// File: rtl/xbar_seg_enforcer_pkg.sv
// Shared definitions for the segmented crossbar priority enforcer.
//   state_t / ST_*  : FSM encoding (legacy-compatible localparam constants)
//   clog2, max1     : elaboration-time helpers for derived widths
package xbar_seg_enforcer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_SCAN  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/xbar_seg_enforcer_prio.sv
// Combinational lowest-set-bit picker for one segment.
//   vec_i    : candidate bits (already masked)
//   onehot_o : one-hot lowest set bit (0 when vec_i is empty)
//   idx_o    : bit position of the winner
//   any_o    : vec_i has at least one bit set
//   above_o  : ones strictly above the winner bit (0 when vec_i is empty)
module xbar_seg_prio
  import xbar_seg_enforcer_pkg::*;
#(
  parameter  int W  = 8,
  localparam int BW = max1(clog2(W))
) (
  input  logic [W-1:0]  vec_i,
  output logic [W-1:0]  onehot_o,
  output logic [BW-1:0] idx_o,
  output logic          any_o,
  output logic [W-1:0]  above_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    // Walk from the top down so the last hit is the lowest set bit.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = BW'(i);
        any_o       = 1'b1;
      end
    end
  end

  always_comb begin
    above_o = '0;
    for (int i = 0; i < W; i++) begin
      above_o[i] = any_o & (i > int'(idx_o));
    end
  end

endmodule

// File: rtl/xbar_seg_enforcer.sv
// Segmented crossbar priority enforcer for one NoC output port.
// Scans NUM_REQ request lines SEG_W at a time, registers a one-hot winner
// and holds it under a valid/ack handshake. Round-robin within a segment
// via a strictly-above mask; revokes the grant if the winner withdraws.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_req         : level-sensitive request vector
//   i_ack         : winner consumed (looked at only while o_valid=1)
//   o_valid       : winner valid
//   o_winner      : one-hot winner within segment o_seg
//   o_seg         : segment index of the winner
//   o_winner_idx  : absolute index = o_seg*SEG_W + bit position
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_SCAN  | examine segment seg_q under mask_q; grant or move on
// ST_GRANT | winner registered and held until ack or withdrawal
module xbar_seg_enforcer
  import xbar_seg_enforcer_pkg::*;
#(
  parameter  int NUM_REQ    = 22,
  parameter  int SEG_W      = 8,
  parameter  int SKIP_EMPTY = 0,
  localparam int NUM_SEG    = (NUM_REQ + SEG_W - 1) / SEG_W,
  localparam int SEG_BITS   = max1(clog2(NUM_SEG)),
  localparam int IDX_BITS   = max1(clog2(NUM_REQ))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic                i_ack,
  output logic                o_valid,
  output logic [SEG_W-1:0]    o_winner,
  output logic [SEG_BITS-1:0] o_seg,
  output logic [IDX_BITS-1:0] o_winner_idx
);

  localparam int PAD_W    = NUM_SEG * SEG_W;
  localparam int BW       = max1(clog2(SEG_W));
  // Highest real bit position inside the (possibly partial) last segment.
  localparam int LAST_TOP = NUM_REQ - 1 - (NUM_SEG - 1) * SEG_W;

  state_t              state_q, state_d;
  logic [SEG_BITS-1:0] seg_q, seg_d;
  logic [SEG_W-1:0]    mask_q, mask_d;
  logic [SEG_W-1:0]    win_q, win_d;
  logic [SEG_BITS-1:0] oseg_q, oseg_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [SEG_W-1:0]    above_q, above_d;

  // Zero-padding keeps bits above NUM_REQ permanently inactive.
  logic [PAD_W-1:0]   req_pad;
  logic [SEG_W-1:0]   seg_req_a [NUM_SEG];
  logic [NUM_SEG-1:0] seg_any;

  assign req_pad = PAD_W'(i_req);

  for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
    assign seg_req_a[s] = req_pad[s*SEG_W +: SEG_W];
    assign seg_any[s]   = |seg_req_a[s];
  end

  logic [SEG_W-1:0] seg_req;
  logic [SEG_W-1:0] masked;

  always_comb begin
    seg_req = '0;
    for (int s = 0; s < NUM_SEG; s++) begin
      if (seg_q == SEG_BITS'(s)) seg_req = seg_req_a[s];
    end
  end

  assign masked = seg_req & mask_q;

  logic [SEG_W-1:0] p_onehot;
  logic [BW-1:0]    p_idx;
  logic             p_any;
  logic [SEG_W-1:0] p_above;

  xbar_seg_prio #(.W(SEG_W)) u_prio (
    .vec_i    (masked),
    .onehot_o (p_onehot),
    .idx_o    (p_idx),
    .any_o    (p_any),
    .above_o  (p_above)
  );

  logic [SEG_BITS-1:0] seg_inc;
  logic [SEG_BITS-1:0] seg_skip;
  logic                skip_found;

  assign seg_inc = (seg_q == SEG_BITS'(NUM_SEG - 1)) ? '0 : seg_q + 1'b1;

  // First segment strictly after seg_q (cyclically) holding any request;
  // falls back to a single-step advance when no other segment is active.
  always_comb begin
    int c;
    seg_skip   = seg_inc;
    skip_found = 1'b0;
    for (int k = 1; k < NUM_SEG; k++) begin
      c = int'(seg_q) + k;
      if (c >= NUM_SEG) c = c - NUM_SEG;
      for (int s = 0; s < NUM_SEG; s++) begin
        if (!skip_found && (s == c) && seg_any[s]) begin
          seg_skip   = SEG_BITS'(s);
          skip_found = 1'b1;
        end
      end
    end
  end

  logic win_live;
  logic is_top;

  // During GRANT seg_q still points at the winner's segment.
  assign win_live = |(seg_req & win_q);
  assign is_top   = (oseg_q == SEG_BITS'(NUM_SEG - 1)) ? (bit_q == BW'(LAST_TOP))
                                                       : (bit_q == BW'(SEG_W - 1));

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    mask_d  = mask_q;
    win_d   = win_q;
    oseg_d  = oseg_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    above_d = above_q;
    if (state_q == ST_SCAN) begin
      if (p_any) begin
        state_d = ST_GRANT;
        win_d   = p_onehot;
        oseg_d  = seg_q;
        idx_d   = IDX_BITS'(int'(seg_q) * SEG_W + int'(p_idx));
        bit_d   = p_idx;
        above_d = p_above;
      end else begin
        seg_d  = (SKIP_EMPTY != 0) ? seg_skip : seg_inc;
        mask_d = '1;
      end
    end else begin
      // Ack wins over a simultaneous withdrawal.
      if (i_ack) begin
        state_d = ST_SCAN;
        if (is_top) begin
          mask_d = '1;
          seg_d  = seg_inc;
        end else begin
          mask_d = above_q;
        end
      end else if (!win_live) begin
        state_d = ST_SCAN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      seg_q   <= '0;
      mask_q  <= '1;
      win_q   <= '0;
      oseg_q  <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      above_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      mask_q  <= mask_d;
      win_q   <= win_d;
      oseg_q  <= oseg_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      above_q <= above_d;
    end
  end

  assign o_valid      = (state_q == ST_GRANT);
  assign o_winner     = win_q;
  assign o_seg        = oseg_q;
  assign o_winner_idx = idx_q;

endmodule

// File: tb/tb_xbar_seg_enforcer.sv
module tb_xbar_seg_enforcer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] req, req2;
  logic        ack, ack2;
  logic        v1, v2;
  logic [7:0]  w1, w2;
  logic [1:0]  s1, s2;
  logic [4:0]  i1, i2;

  always #5 clk = ~clk;

  xbar_seg_enforcer #(.NUM_REQ(22), .SEG_W(8), .SKIP_EMPTY(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_ack(ack),
    .o_valid(v1), .o_winner(w1), .o_seg(s1), .o_winner_idx(i1)
  );

  xbar_seg_enforcer #(.NUM_REQ(22), .SEG_W(8), .SKIP_EMPTY(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_req(req2), .i_ack(ack2),
    .o_valid(v2), .o_winner(w2), .o_seg(s2), .o_winner_idx(i2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          sel;
    logic [21:0] req;
    bit          ack;
    bit          ev;
    logic [7:0]  ew;
    logic [1:0]  es;
    logic [4:0]  ei;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit sel, input logic [21:0] rq, input bit a,
                     input bit ev, input logic [7:0] ew, input logic [1:0] es,
                     input logic [4:0] ei);
    vec_t v;
    v.rst = rst; v.sel = sel; v.req = rq; v.ack = a;
    v.ev = ev; v.ew = ew; v.es = es; v.ei = ei;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req2 = '0; ack = 1'b0; ack2 = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic av;
    logic [7:0] aw;
    logic [1:0] a_seg;
    logic [4:0] ai;

    rst_n = 1'b0;
    req = '0; req2 = '0; ack = 1'b0; ack2 = 1'b0;

    @(negedge clk);
    chk("rst_valid", 0, 32'(v1), 32'd0);
    chk("rst_winner", 0, 32'(w1), 32'd0);
    chk("rst_seg", 0, 32'(s1), 32'd0);
    chk("rst_idx", 0, 32'(i1), 32'd0);
    chk("rst_valid2", 0, 32'(v2), 32'd0);
    rst_n = 1'b1;

    // Idle scan: segment pointer steps 0,1,2,0,... and nothing is granted.
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("idle_valid", k, 32'(v1), 32'd0);
      chk("idle_oseg", k, 32'(s1), 32'd0);
      chk("idle_seg", k, 32'(dut.seg_q), 32'(k % 3));
      chk("idle_seg_skip", k, 32'(dut2.seg_q), 32'(k % 3));
    end

    // A: req=0x5, ack whenever valid -> idx 0, idx 2, scan seg1/seg2, idx 0
    add(1, 0, 22'h5, 1, 1, 8'h01, 2'd0, 5'd0);
    add(0, 0, 22'h5, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h5, 1, 1, 8'h04, 2'd0, 5'd2);
    add(0, 0, 22'h5, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h5, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h5, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h5, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h5, 1, 1, 8'h01, 2'd0, 5'd0);
    // B: idx 9 held 5 cycles while bit 8 arrives; bit 8 waits for seg1 revisit
    add(1, 0, 22'h200, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h200, 0, 1, 8'h02, 2'd1, 5'd9);
    for (int k = 0; k < 5; k++) add(0, 0, 22'h300, 0, 1, 8'h02, 2'd1, 5'd9);
    add(0, 0, 22'h300, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h300, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h300, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h300, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h300, 0, 1, 8'h01, 2'd1, 5'd8);
    // C: withdrawal revokes with mask kept; ack + withdrawal counts as ack
    add(1, 0, 22'h200, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h200, 0, 1, 8'h02, 2'd1, 5'd9);
    add(0, 0, 22'h100, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h100, 0, 1, 8'h01, 2'd1, 5'd8);
    add(0, 0, 22'h000, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h100, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h100, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h100, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h100, 0, 1, 8'h01, 2'd1, 5'd8);
    // D: ack of top bit 7 advances straight to seg1 with a full mask
    add(1, 0, 22'h180, 0, 1, 8'h80, 2'd0, 5'd7);
    add(0, 0, 22'h180, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h180, 0, 1, 8'h01, 2'd1, 5'd8);
    // E: idx 21 is the top real bit of the partial last segment
    add(1, 0, 22'h200001, 0, 1, 8'h01, 2'd0, 5'd0);
    add(0, 0, 22'h200001, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h200001, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h200001, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h200001, 0, 1, 8'h20, 2'd2, 5'd21);
    add(0, 0, 22'h200001, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 0, 22'h200001, 0, 1, 8'h01, 2'd0, 5'd0);
    // F: SKIP_EMPTY=1 jumps seg0->seg2, then seg2->seg1 past empty seg0
    add(1, 1, 22'h20000, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 1, 22'h20000, 0, 1, 8'h02, 2'd2, 5'd17);
    add(0, 1, 22'h01000, 1, 0, 8'h00, 2'd0, 5'd0);
    add(0, 1, 22'h01000, 0, 0, 8'h00, 2'd0, 5'd0);
    add(0, 1, 22'h01000, 0, 1, 8'h10, 2'd1, 5'd12);

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      if (v.rst) do_reset();
      if (v.sel) begin
        req2 = v.req; ack2 = v.ack; req = '0; ack = 1'b0;
      end else begin
        req = v.req; ack = v.ack; req2 = '0; ack2 = 1'b0;
      end
      @(negedge clk);
      av    = v.sel ? v2 : v1;
      aw    = v.sel ? w2 : w1;
      a_seg = v.sel ? s2 : s1;
      ai    = v.sel ? i2 : i1;
      chk("vec_valid", r, 32'(av), 32'(v.ev));
      if (v.ev) begin
        chk("vec_winner", r, 32'(aw), 32'(v.ew));
        chk("vec_seg", r, 32'(a_seg), 32'(v.es));
        chk("vec_idx", r, 32'(ai), 32'(v.ei));
      end
    end

    // Asynchronous reset in the middle of a GRANT on idx 9.
    do_reset();
    req = 22'h200;
    @(negedge clk);
    @(negedge clk);
    chk("mid_grant_valid", 0, 32'(v1), 32'd1);
    chk("mid_grant_idx", 0, 32'(i1), 32'd9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 0, 32'(v1), 32'd0);
    chk("arst_seg", 0, 32'(s1), 32'd0);
    chk("arst_winner", 0, 32'(w1), 32'd0);
    chk("arst_idx", 0, 32'(i1), 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 0, 32'(v1), 32'd0);
    @(negedge clk);
    chk("post_rst_valid", 1, 32'(v1), 32'd0);
    @(negedge clk);
    chk("post_rst_valid", 2, 32'(v1), 32'd1);
    chk("post_rst_idx", 2, 32'(i1), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
